// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO (ports: clk, rst, start, op, rs_val, rt_val -> busy, done, hi, lo)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rs;
  logic [2*WIDTH-1:0] r_acc;
  logic               w_sgn;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  // r_acc holds {upper, lower}: for multiply {partial product, remaining multiplier},
  // for divide {partial remainder, dividend bits shifting out / quotient bits shifting in}
  always_comb begin
    w_sgn   = ~op[0];
    w_a_mag = (w_sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    w_b_mag = (w_sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_acc[0]}} & r_b};
    w_rem   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff  = w_rem - {1'b0, r_b};
    w_step  = !r_div ? {w_sum, r_acc[WIDTH-1:1]} :
              w_diff[WIDTH] ? {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                              {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    w_prod  = r_neg_q ? -r_acc : r_acc;
    w_q     = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_r     = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (!op[2]) begin
            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
            r_b     <= w_b_mag;
            r_rs    <= rs_val;
            r_div   <= op[1];
            r_neg_q <= w_sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            r_neg_r <= w_sgn & rs_val[WIDTH-1];
            r_cnt   <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            r_state <= CALC;
          end else if (!op[1]) begin
            if (op[0]) lo <= rs_val;
            else hi <= rs_val;
          end
        end
        CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= FINISH;
        end
        FINISH: begin
          hi      <= !r_div ? w_prod[2*WIDTH-1:WIDTH] : (r_b == '0 ? r_rs : w_r);
          lo      <= !r_div ? w_prod[WIDTH-1:0] : (r_b == '0 ? '1 : w_q);
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  int tests = 0;
  int fails = 0;
  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    h = '0;
    l = '0;
    if (o == 3'd0) begin
      sp = longint'(sa) * longint'(sb);
      {h, l} = sp;
    end else if (o == 3'd1) begin
      up = {32'd0, a} * {32'd0, b};
      {h, l} = up;
    end else if (b == 0) begin
      l = 32'hFFFF_FFFF;
      h = a;
    end else if (o == 3'd3) begin
      l = a / b;
      h = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      l = 32'h8000_0000;
      h = '0;
    end else begin
      l = sa / sb;
      h = sa % sb;
    end
  endfunction
  // Issues one arithmetic op, hammers the inputs with random strobes while busy,
  // and checks latency, HI/LO stability during the op, and the final result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] h0;
    logic [31:0] l0;
    int          n;
    bit          held;
    model(o, a, b, eh, el);
    @(negedge clk);
    h0 = hi;
    l0 = lo;
    start = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    n = 0;
    held = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      start = 1'($urandom);
      op = 3'($urandom);
      rs_val = $urandom;
      rt_val = $urandom;
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      held &= (busy === 1'b1 && hi === h0 && lo === l0);
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " held_while_busy"}, 64'(held), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask
  task automatic move(input logic [2:0] o, input logic [31:0] a, input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    eh = (o == 3'd4) ? a : hi;
    el = (o == 3'd5) ? a : lo;
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs_val = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
  endtask
  initial begin
    logic [31:0] pool [6];
    logic [31:0] a;
    logic [31:0] b;
    bit          saw_done;
    pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    move(3'd4, 32'h1234_5678, "mthi");
    move(3'd5, 32'h9ABC_DEF0, "mtlo");
    move(3'd6, 32'h5555_5555, "nop");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'd3, 32'd100, 32'd7, "divu");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd3, 32'd55, 32'd0, "divu_zero");
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, "div_zero");
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, "div_posneg");
    run_op(3'd1, 32'd6, 32'd7, "multu_disturbed");
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      run_op(3'($urandom_range(0, 3)), a, b, $sformatf("rand%0d", i));
    end
    @(negedge clk);
    start = 1'b1;
    op = 3'd1;
    rs_val = 32'd6;
    rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      saw_done |= done;
    end
    check("abort no_done", 64'(saw_done), 64'd0);
    check("abort hi_after", 64'(hi), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
